// File: rtl/inst_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_pkg
// Description : Shared widths, encodings and helpers for the instruction
//               fetch unit and its prefetch queue.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_fetch_pkg;

    // Bus widths
    localparam int INST_ADDR_BUS  = 32;
    localparam int INST_BUS       = 32;

    // Encodings
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic        CHIP_ENABLE  = 1'b1;
    localparam logic        CHIP_DISABLE = 1'b0;

    // Prefetch queue geometry
    localparam int IFQ_DEPTH      = 4;
    localparam int IFQ_DEPTH_LOG2 = 2;
    localparam int IFQ_WIDTH      = INST_ADDR_BUS + INST_BUS;

    // One queued fetch result
    typedef struct packed {
        logic [INST_ADDR_BUS-1:0] pc;
        logic [INST_BUS-1:0]      inst;
    } ifq_entry_t;

    // Force a byte address onto a word boundary
    function automatic logic [INST_ADDR_BUS-1:0] word_align(
        input logic [INST_ADDR_BUS-1:0] addr
    );
        return {addr[INST_ADDR_BUS-1:2], 2'b00};
    endfunction

endpackage : inst_fetch_pkg
`default_nettype wire

// File: rtl/inst_fetch_ifq_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ifq_fifo
// Description : Synchronous FIFO used as the instruction prefetch queue.
//               Flush has priority over push and pop. Storage contents are
//               not reset; only pointers and occupancy are.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               i_push/i_wdata - write request and data
//               i_pop          - remove head entry (ignored when empty)
//               i_flush        - discard all entries
//               o_rdata        - head entry (valid when !o_empty)
//               o_full/o_empty/o_count - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module ifq_fifo
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH      = IFQ_DEPTH,
    parameter int DEPTH_LOG2 = IFQ_DEPTH_LOG2,
    parameter int WIDTH      = IFQ_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic                  i_pop,
    input  logic                  i_flush,
    output logic [WIDTH-1:0]      o_rdata,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count
);

    localparam logic [DEPTH_LOG2:0] c_full_count = DEPTH[DEPTH_LOG2:0];

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2:0]   r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_full    = (r_count == c_full_count);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];

    // A push into a full queue is accepted when the head leaves at the same edge.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule : ifq_fifo
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch
// Description : Instruction fetch unit with a 4-entry prefetch queue.
//               Issues word fetches to a combinational ROM, captures the
//               returned instruction with its PC, and presents the queue
//               head to the decode stage with a valid/ready handshake.
//               A branch redirect flushes the queue and reloads the PC.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               rom_ce_o        - ROM chip enable (high on each issue)
//               rom_addr_o      - ROM byte address (zero when idle)
//               rom_inst_i      - ROM read data, same cycle
//               branch_flag_i   - redirect request
//               branch_target_i - redirect address (low 2 bits dropped)
//               id_ready_i      - decode accepts head entry
//               if_valid_o      - head entry valid
//               if_pc_o         - head PC (zero when not valid)
//               if_inst_o       - head instruction (zero when not valid)
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    output logic                     rom_ce_o,
    output logic [INST_ADDR_BUS-1:0] rom_addr_o,
    input  logic [INST_BUS-1:0]      rom_inst_i,
    input  logic                     branch_flag_i,
    input  logic [INST_ADDR_BUS-1:0] branch_target_i,
    input  logic                     id_ready_i,
    output logic                     if_valid_o,
    output logic [INST_ADDR_BUS-1:0] if_pc_o,
    output logic [INST_BUS-1:0]      if_inst_o
);

    localparam logic [IFQ_DEPTH_LOG2:0] c_full_count = IFQ_DEPTH[IFQ_DEPTH_LOG2:0];

    logic [INST_ADDR_BUS-1:0] r_fetch_pc;
    logic                     r_en;

    logic                     w_issue;
    logic                     w_pop;
    logic                     w_valid;
    logic                     w_full;
    logic                     w_empty;
    logic [IFQ_DEPTH_LOG2:0]  w_count;
    ifq_entry_t               w_push_entry;
    ifq_entry_t               w_head_entry;

    assign w_valid = ~w_empty;
    assign w_pop   = w_valid & id_ready_i;

    // A full queue may still fetch when the head is consumed this cycle.
    // A redirect suppresses the fetch so the stale path is never requested.
    assign w_issue = r_en & ~branch_flag_i & (~w_full | w_pop);

    assign w_push_entry.pc   = r_fetch_pc;
    assign w_push_entry.inst = rom_inst_i;

    ifq_fifo #(
        .DEPTH      (IFQ_DEPTH),
        .DEPTH_LOG2 (IFQ_DEPTH_LOG2),
        .WIDTH      (IFQ_WIDTH)
    ) u_ifq_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_issue),
        .i_wdata (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (branch_flag_i),
        .o_rdata (w_head_entry),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Fetch PC and run flag. en rises on the first edge out of reset so the
    // first ROM access happens one cycle after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= ZERO_WORD;
            r_en       <= 1'b0;
        end else begin
            r_en <= 1'b1;
            if (branch_flag_i) begin
                r_fetch_pc <= word_align(branch_target_i);
            end else if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;   // wraps modulo 2^32
            end
        end
    end

    // Occupancy sanity: the queue never exceeds its depth and the full flag
    // agrees with the count.
    always @(posedge clk) begin
        if (!rst) begin
            assert (w_count <= c_full_count);
            assert (w_full == (w_count == c_full_count));
        end
    end

    assign rom_ce_o   = w_issue ? CHIP_ENABLE : CHIP_DISABLE;
    assign rom_addr_o = w_issue ? r_fetch_pc : ZERO_WORD;

    assign if_valid_o = w_valid;
    assign if_pc_o    = w_valid ? w_head_entry.pc   : ZERO_WORD;
    assign if_inst_o  = w_valid ? w_head_entry.inst : ZERO_WORD;

endmodule : inst_fetch
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch
// Description : Self-checking bench for inst_fetch. A queue-based reference
//               model predicts ROM requests and decode-side outputs every
//               cycle under directed and random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_inst_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        id_ready_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;

    int n_checks;
    int n_pass;

    // Reference model state
    logic [31:0] m_pc;
    bit          m_en;
    logic [63:0] m_q[$];

    inst_fetch u_dut (
        .clk             (clk),
        .rst             (rst),
        .rom_ce_o        (rom_ce_o),
        .rom_addr_o      (rom_addr_o),
        .rom_inst_i      (rom_inst_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .id_ready_i      (id_ready_i),
        .if_valid_o      (if_valid_o),
        .if_pc_o         (if_pc_o),
        .if_inst_o       (if_inst_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM[i] = i + 0x100 (word-indexed)
    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        return (addr >> 2) + 32'h100;
    endfunction

    assign rom_inst_i = rom_word(rom_addr_o);

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ce"},    {31'd0, rom_ce_o},   32'd0);
        check_val({tag, "_addr"},  rom_addr_o,          32'd0);
        check_val({tag, "_valid"}, {31'd0, if_valid_o}, 32'd0);
        check_val({tag, "_pc"},    if_pc_o,             32'd0);
        check_val({tag, "_inst"},  if_inst_o,           32'd0);
    endtask

    // Entered at a falling edge; applies reset asynchronously and releases it
    // before the next rising edge.
    task automatic do_reset();
        rst             = 1'b1;
        branch_flag_i   = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs("rst_hold");
        rst  = 1'b0;
        m_pc = 32'h0;
        m_en = 1'b0;
        m_q.delete();
    endtask

    // One clock cycle: drive, compare against model, advance model at the edge.
    task automatic step(input bit ready, input bit br, input logic [31:0] tgt);
        bit          exp_valid;
        bit          exp_pop;
        bit          exp_issue;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        logic [31:0] exp_addr;

        id_ready_i      = ready;
        branch_flag_i   = br;
        branch_target_i = tgt;
        #1;
        exp_valid = (m_q.size() != 0);
        exp_pc    = exp_valid ? m_q[0][63:32] : 32'h0;
        exp_inst  = exp_valid ? m_q[0][31:0]  : 32'h0;
        exp_pop   = exp_valid && ready;
        exp_issue = m_en && !br && ((m_q.size() < 4) || exp_pop);
        exp_addr  = exp_issue ? m_pc : 32'h0;

        check_val("if_valid", {31'd0, if_valid_o}, {31'd0, exp_valid});
        check_val("if_pc",    if_pc_o,             exp_pc);
        check_val("if_inst",  if_inst_o,           exp_inst);
        check_val("rom_ce",   {31'd0, rom_ce_o},   {31'd0, exp_issue});
        check_val("rom_addr", rom_addr_o,          exp_addr);

        @(posedge clk);
        if (br) begin
            m_q.delete();
            m_pc = {tgt[31:2], 2'b00};
        end else begin
            if (exp_pop) void'(m_q.pop_front());
            if (exp_issue) begin
                m_q.push_back({m_pc, rom_word(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
        m_en = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        n_checks        = 0;
        n_pass          = 0;
        rst             = 1'b1;
        branch_flag_i   = 1'b0;
        branch_target_i = 32'h0;
        id_ready_i      = 1'b0;
        m_pc            = 32'h0;
        m_en            = 1'b0;

        @(negedge clk);
        do_reset();

        // Streaming from reset with decode always ready
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 32'h0);

        // Stall decode: queue fills, ROM goes idle, then drain in order
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0);

        // Redirect with a partially full queue and a misaligned target
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h0000_0203);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0);

        // Address wrap across 2^32
        step(1'b1, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0);

        // Redirect held for several cycles with changing targets
        step(1'b0, 1'b1, 32'h0000_1000);
        step(1'b1, 1'b1, 32'h0000_2001);
        step(1'b1, 1'b1, 32'h0000_3002);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);

        // Full queue with continuous consumption
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0);

        // Reset mid-operation while full and ready
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0);
        id_ready_i = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit          r_rdy;
            bit          r_br;
            logic [31:0] r_tgt;
            r_rdy = ($urandom % 4) != 0;
            r_br  = ($urandom % 16) == 0;
            r_tgt = $urandom;
            if (($urandom % 4) == 0) r_tgt = 32'hFFFF_FFE0 | ($urandom % 32);
            if (($urandom % 3) == 0) r_rdy = 1'b0;
            step(r_rdy, r_br, r_tgt);
            if (($urandom % 500) == 0) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_inst_fetch
`default_nettype wire

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 rom_ce_o  output  1  instruction ROM chip enable, using `ChipEnable/`ChipDisable encoding.
REQ-004 rom_addr_o  output  `InstAddrBus (32)  byte address to ROM; bits [1:0] always 0.
REQ-005 rom_inst_i  input  `InstBus (32)  ROM read data, combinational from rom_ce_o/rom_addr_o in the same cycle.
REQ-006 branch_flag_i  input  1  redirect request from execute stage.
REQ-007 branch_target_i  input  32  redirect byte address; bits [1:0] ignored and forced to 0.
REQ-008 id_ready_i  input  1  decode stage accepts head entry this cycle.
REQ-009 if_valid_o  output  1  head entry of the prefetch queue is valid.
REQ-010 if_pc_o  output  32  PC of the head entry; `ZeroWord when if_valid_o=0.
REQ-011 if_inst_o  output  32  instruction of the head entry; `ZeroWord when if_valid_o=0.

Function
REQ-012 The block holds fetch_pc (32 bits), run flag en, and a 4-entry prefetch queue of {pc, inst} pairs.
- REQ-013 en is 0 in reset, becomes 1 on the first rising edge after rst deasserts, and stays 1.
- REQ-014 issue = en & !branch_flag_i & (count<4 | pop); rom_ce_o = issue; rom_addr_o = fetch_pc when issue, else `ZeroWord.
- REQ-015 On issue, the queue captures {fetch_pc, rom_inst_i} at the same edge, and fetch_pc advances by 4. Latency from issue to availability at if_*_o is 1 cycle.
- REQ-016 fetch_pc arithmetic is modulo 2^32: 0xFFFFFFFC advances to 0x00000000.
- REQ-017 pop = if_valid_o & id_ready_i; the head entry is removed at the edge, and the next entry appears the following cycle.
- REQ-018 Simultaneous push and pop when full (count=4) is legal; count stays 4, and order is preserved.
- REQ-019 Push into empty queue: the entry is visible on the next cycle; there is no same-cycle bypass to if_*_o.
- REQ-020 id_ready_i while if_valid_o=0 has no effect.
- REQ-021 branch_flag_i=1: at the edge, the queue is emptied (count=0), fetch_pc <= {branch_target_i[31:2],2'b00}, no issue occurs this cycle, and any pop this cycle is discarded. The branch has priority over push and pop.
- REQ-022 After a redirect, the first fetch (of the target address) occurs in the next cycle. if_valid_o is 0 for exactly one cycle after the redirect edge.
- REQ-023 branch_flag_i held for multiple cycles: each cycle re-applies REQ-021 with the current target.
- REQ-024 count is never >4 and never <0. The queue wraps its read/write pointers modulo 4.

Reset
REQ-025 While rst=1, the following hold: fetch_pc=0x00000000, en=0, count=0, pointers=0, rom_ce_o=`ChipDisable, rom_addr_o=`ZeroWord, if_valid_o=0, if_pc_o=`ZeroWord, if_inst_o=`ZeroWord.
REQ-026 Reset asserted mid-operation takes effect immediately (asynchronously) and discards all queued entries; fetching restarts from 0x00000000 per REQ-013.
REQ-027 Queue storage data need not be reset; only valid/count/pointer state is reset.

Structure
REQ-028 Widths and encodings come from defines.v: `InstAddrBus, `InstBus, `ZeroWord, `ChipEnable, `ChipDisable. New defines go there as well: `IfqDepth (4) and `IfqDepthLog2 (2).
REQ-029 The queue is one sub-module, ifq_fifo: a synchronous FIFO with push, pop, flush, full, empty, and count outputs, depth `IfqDepth, and width 64.
REQ-030 inst_fetch instantiates ifq_fifo and contains the fetch_pc/en logic. It replaces the standalone PC module at the ROM interface in sopc.

Verification
REQ-031 Reset release, ROM[i]=i+0x100, id_ready_i=1 -> the ROM sees addresses 0,4,8,... from cycle 2; the decode stage receives (0,0x100),(4,0x101),... with one entry per cycle and no gaps.
REQ-032 id_ready_i=0 for 10 cycles -> exactly 4 issues and then rom_ce_o=0. With id_ready_i=1 afterwards, the PCs 0,4,8,C are delivered in order, and fetch resumes at 0x10.
REQ-033 With the queue holding 3 entries, assert branch_flag_i=1 with target 0x00000203 -> the next cycle has rom_addr_o=0x200 and if_valid_o=0. The cycle after that has if_pc_o=0x200, and no stale entries are ever delivered.
REQ-034 With fetch_pc forced to 0xFFFFFFF8 via branch -> delivered PCs are 0xFFFFFFF8, 0xFFFFFFFC, then 0x00000000.
REQ-035 Assert rst for 1 cycle while the queue is full and id_ready_i=1 -> all outputs go to reset values immediately; the first delivered PC after reset is 0x00000000.
REQ-036 Full queue, id_ready_i=1 continuously -> each cycle has one pop and one push, count stays at 4, and PCs are contiguous.
